// File: rtl/instr_fetch_buffer.sv
// Fetch buffer between the PC stage and decode: issues in-order imem requests and queues returned words.
// Optional misaligned-PC fault marking is enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          flush,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  output logic          instr_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

  logic [AW-1:0]    pc_q [DEPTH];
  logic [AW-1:0]    pc_d [DEPTH];
  logic [DW-1:0]    instr_q [DEPTH];
  logic [DW-1:0]    instr_d [DEPTH];
  logic [DEPTH-1:0] fault_q, fault_d, filled_q, filled_d;
  logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d, fill_ptr_q, fill_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, pend_q, pend_d, drop_cnt_q, drop_cnt_d;

  logic          misalign, accept_ok, alloc, fill, pop;
  logic [CW-1:0] drop_total;

  always_comb begin
    misalign    = ALIGN_EN && (pc_in[1:0] != 2'b00);
    accept_ok   = pc_valid && (count_q < CW'(DEPTH)) && !flush && (drop_cnt_q == '0);
    imem_req    = accept_ok && !misalign;
    imem_addr   = pc_in;
    // A faulting PC bypasses memory, so it may only enter once all earlier fetches have returned.
    pc_ready    = (imem_req && imem_gnt) || (accept_ok && misalign && (pend_q == '0));
    alloc       = pc_ready;
    fill        = imem_rvalid && !flush && (drop_cnt_q == '0) && (pend_q != '0);
    instr_valid = !flush && filled_q[rd_ptr_q] && (count_q != '0);
    pop         = instr_valid && instr_ready;
    instr_out   = instr_q[rd_ptr_q];
    instr_pc    = pc_q[rd_ptr_q];
    instr_fault = ALIGN_EN && fault_q[rd_ptr_q];
    drop_total  = drop_cnt_q + pend_q;
  end

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    fault_d     = fault_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(alloc) - CW'(pop);
    pend_d      = pend_q + CW'(alloc && !misalign) - CW'(fill);
    drop_cnt_d  = drop_cnt_q;

    if (alloc) begin
      pc_d[alloc_ptr_q]     = pc_in;
      fault_d[alloc_ptr_q]  = misalign;
      filled_d[alloc_ptr_q] = misalign;
      alloc_ptr_d           = alloc_ptr_q + PW'(1);
      if (misalign) begin
        instr_d[alloc_ptr_q] = NOP;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end
    end
    if (fill) begin
      instr_d[fill_ptr_q]  = imem_rdata;
      filled_d[fill_ptr_q] = 1'b1;
      fill_ptr_d           = fill_ptr_q + PW'(1);
    end
    if (pop) begin
      filled_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + PW'(1);
    end
    if (imem_rvalid && !flush && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);

    // Everything still owed by memory becomes a drop; a response landing now pays one off.
    if (flush) begin
      drop_cnt_d  = drop_total - CW'(imem_rvalid && (drop_total != '0));
      count_d     = '0;
      pend_d      = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      filled_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      fault_q     <= '0;
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      fault_q     <= fault_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer; a 1-cycle memory model answers grants with 0xA0 + (addr >> 2).
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mem_auto = 1'b1;

  instr_fetch_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'hA0 + (pc >> 2);
    e.fault = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) begin
      e.instr = 32'h0000_0013;
      e.fault = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic issue_pc(input logic [31:0] pc, input bit push, input bit tog);
    bit done;
    done     = 1'b0;
    pc_in    = pc;
    pc_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (pc_ready) begin
        if (push) exp_q.push_back(mk(pc));
        done = 1'b1;
      end
      tick();
      if (tog) instr_ready = ~instr_ready;
    end
    pc_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: pc %0h got no pc_ready, required acceptance within 40 cycles", pc);
    end
  endtask

  task automatic drain(input string name);
    instr_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Memory model: a grant seen before an edge is answered in the following cycle.
  initial begin
    logic        hit;
    logic [31:0] addr;
    forever begin
      @(negedge clk);
      hit  = imem_req & imem_gnt & rst_n;
      addr = imem_addr;
      @(posedge clk);
      #1;
      if (mem_auto) begin
        imem_rvalid = hit;
        imem_rdata  = 32'hA0 + (addr >> 2);
      end
    end
  end

  // Scoreboard monitor: every accepted instruction must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_instr: got pc=%0h instr=%0h, required no output", instr_pc, instr_out);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e.pc || instr_out !== e.instr || instr_fault !== e.fault) begin
            n_fail++;
            $display("FAIL sb_instr: got pc=%0h instr=%0h fault=%0b, required pc=%0h instr=%0h fault=%0b",
                     instr_pc, instr_out, instr_fault, e.pc, e.instr, e.fault);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_in = '0; pc_valid = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; flush = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_imem_req",    64'(imem_req),    64'd0);
    check("rst_pc_ready",    64'(pc_ready),    64'd0);
    check("rst_instr_out",   64'(instr_out),   64'd0);
    check("rst_instr_pc",    64'(instr_pc),    64'd0);
    check("rst_instr_fault", 64'(instr_fault), 64'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream: first word reaches decode two cycles after its grant.
    imem_gnt = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'(i * 4); pc_valid = 1'b1;
      #1;
      check("t1_pc_ready", 64'(pc_ready), 64'd1);
      check("t1_valid_latency", 64'(instr_valid), 64'(i >= 2));
      exp_q.push_back(mk(32'(i * 4)));
      tick();
    end
    pc_valid = 1'b0;
    drain("t1_drain");

    // Full buffer holds off the fifth PC until the cycle after a pop.
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'h100 + 32'(i * 4); pc_valid = 1'b1;
      #1;
      check("t2_accept", 64'(pc_ready), 64'd1);
      exp_q.push_back(mk(32'h100 + 32'(i * 4)));
      tick();
    end
    pc_in = 32'h110;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_full_hold", 64'(pc_ready), 64'd0);
      check("t2_full_req",  64'(imem_req), 64'd0);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    check("t2_pop_cycle_ready", 64'(pc_ready), 64'd0);
    check("t2_pop_cycle_valid", 64'(instr_valid), 64'd1);
    tick();
    #1;
    check("t2_after_pop_ready", 64'(pc_ready), 64'd1);
    exp_q.push_back(mk(32'h110));
    tick();
    pc_valid = 1'b0;
    drain("t2_drain");

    // Flush with two fetches in flight; both responses must be dropped.
    mem_auto = 1'b0;
    issue_pc(32'h200, 1'b0, 1'b0);
    issue_pc(32'h204, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("t3_flush_valid", 64'(instr_valid), 64'd0);
    check("t3_flush_req",   64'(imem_req),    64'd0);
    tick();
    flush = 1'b0; pc_in = 32'h40; pc_valid = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
    #1;
    check("t3_drop1_ready", 64'(pc_ready), 64'd0);
    tick();
    imem_rdata = 32'hBEEF;
    #1;
    check("t3_drop2_ready", 64'(pc_ready), 64'd0);
    check("t3_drop2_valid", 64'(instr_valid), 64'd0);
    tick();
    imem_rvalid = 1'b0; mem_auto = 1'b1;
    #1;
    check("t3_post_drop_ready", 64'(pc_ready), 64'd1);
    check("t3_post_drop_valid", 64'(instr_valid), 64'd0);
    exp_q.push_back(mk(32'h40));
    tick();
    pc_valid = 1'b0;
    drain("t3_drain");

    // Ten PCs through four entries with decode stalling every other cycle.
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) issue_pc(32'h300 + 32'(i * 4), 1'b1, 1'b1);
    drain("t4_drain");

    // Reset mid-stream with three words buffered.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue_pc(32'h400 + 32'(i * 4), 1'b0, 1'b0);
    tick(); tick();
    check("t5_buffered_valid", 64'(instr_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    check("t5_rst_valid", 64'(instr_valid), 64'd0);
    check("t5_rst_out",   64'(instr_out),   64'd0);
    check("t5_rst_pc",    64'(instr_pc),    64'd0);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    issue_pc(32'h500, 1'b1, 1'b0);
    drain("t5_drain");

    // Misaligned PC.
    instr_ready = 1'b1;
    pc_in = 32'h6; pc_valid = 1'b1;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6_req",   64'(imem_req), 64'd0);
    check("t6_ready", 64'(pc_ready), 64'd1);
    exp_q.push_back(mk(32'h6));
    tick();
    pc_valid = 1'b0;
    #1;
    check("t6_valid", 64'(instr_valid), 64'd1);
    check("t6_fault", 64'(instr_fault), 64'd1);
    check("t6_nop",   64'(instr_out),   64'h13);
`else
    check("t6_req",   64'(imem_req), 64'd1);
    check("t6_ready", 64'(pc_ready), 64'd1);
    exp_q.push_back(mk(32'h6));
    tick();
    pc_valid = 1'b0;
    tick();
    check("t6_valid", 64'(instr_valid), 64'd1);
    check("t6_fault", 64'(instr_fault), 64'd0);
    check("t6_data",  64'(instr_out),   64'hA1);
`endif
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Consumer end of the program-counter path: accepts fetch addresses from the PC stage, issues in-order requests to instruction memory, and buffers returned words with their PC.
- Presents instructions to decode through a valid/ready handshake.
- Supports flush on redirect, discarding in-flight and buffered instructions.
- Sits between the PC stage and decode.

Parameters:
DEPTH, 4, number of buffer entries, counting in-flight requests and filled words; power of two, at least 2
AW, 32, address/PC width
DW, 32, instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
pc_in  in  AW  fetch address from PC stage
pc_valid  in  1  pc_in is valid
pc_ready  out  1  address accepted this cycle
imem_req  out  1  memory request
imem_addr  out  AW  memory address, equal to pc_in
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid; responses return in request order
imem_rdata  in  DW  read data
flush  in  1  discard all buffered and in-flight fetches
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode accepts instruction
instr_out  out  DW  instruction word
instr_pc  out  AW  PC of instr_out
instr_fault  out  1  misaligned-PC fault marker; see Optional Feature

Behaviour:
- Reset: rst_n sampled low at a rising edge clears all pointers, count and drop_cnt, and all filled flags.
  - After that edge: instr_valid=0, imem_req=0, pc_ready=0, instr_out=0, instr_pc=0, instr_fault=0.
  - Reset wins over every other event in the same cycle.
- Storage: ring buffer of DEPTH entries {pc, instr, fault, filled}.
  - Pointers: alloc_ptr, fill_ptr, rd_ptr.
  - count = number of allocated entries, range 0..DEPTH.
- Request path (combinational):
  - space = (count < DEPTH), using the registered count; no same-cycle bypass from a pop.
  - imem_req = pc_valid & space & ~flush & (drop_cnt == 0).
  - imem_addr = pc_in.
  - pc_ready = imem_req & imem_gnt.
- Allocate on pc_ready: entry[alloc_ptr].pc <= pc_in, filled <= 0, alloc_ptr++.
- Fill on imem_rvalid with drop_cnt == 0: entry[fill_ptr].instr <= imem_rdata, filled <= 1, fill_ptr++.
- Memory latency is at least 1 cycle after grant. A response is never consumed in its grant cycle.
- Output path:
  - instr_valid = ~flush & entry[rd_ptr].filled & (count != 0).
  - instr_out, instr_pc and instr_fault come from entry[rd_ptr].
  - Pop on instr_valid & instr_ready: rd_ptr++, filled cleared.
  - Fetch-to-decode latency: response cycle + 1; a word written on imem_rvalid is visible to decode the following cycle.
- count update: +1 on allocate, -1 on pop; simultaneous allocate and pop leaves count unchanged.
- Wrap-around: all pointers wrap modulo DEPTH.
- Full: count == DEPTH holds pc_ready=0 and imem_req=0. The pc_in/pc_valid source must hold its value.
- Empty: instr_valid=0. instr_out holds its last value; it is don't-care.
- Flush (highest priority after reset):
  - In the flush cycle: no allocate, no pop, instr_valid=0.
  - drop_cnt <= number of allocated-but-unfilled entries.
  - A response arriving in the flush cycle counts toward the drop.
  - Next cycle: count=0 and all pointers equal.
- Drop: while drop_cnt != 0, each imem_rvalid decrements drop_cnt and its data is discarded. New requests are blocked until drop_cnt == 0.
- imem_rvalid with no outstanding entry and drop_cnt == 0 is a protocol error: ignored, with no state change.
- Arithmetic: count is log2(DEPTH)+1 bits wide; drop_cnt has the same width.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - On allocate, fault <= (pc_in[1:0] != 0).
  - A faulting entry is marked filled immediately with instr=32'h00000013 (NOP). No memory request is issued (imem_req=0); count still increments.
  - Ordering requirement: while any earlier entry is unfilled, the faulting PC is not accepted (pc_ready=0), so fill order is preserved.
  - instr_fault follows the entry's fault bit at the output.
- Undefined: no check is performed, instr_fault is tied to 0, and misaligned PCs are fetched as-is.

Test Plan:
- Reset, then pc_in=0,4,8,12 with gnt=1 and rvalid one cycle later carrying 0xA0..0xA3, instr_ready=1 -> instr_pc 0,4,8,12 with matching data, first instr_valid two cycles after the first grant.
- instr_ready=0, 5 PCs offered with DEPTH=4 -> pc_ready drops after 4 allocations; raising instr_ready pops entry 0 and the 5th PC is accepted the cycle after the pop.
- 2 requests outstanding, flush asserted, then 2 rvalids (0xDEAD, 0xBEEF) -> both discarded, no instr_valid; next PC 0x40 is accepted only after the second rvalid.
- Full and popping with wrap: 10 sequential PCs through DEPTH=4 with instr_ready toggling -> every PC appears once, in order, none lost or duplicated.
- rst_n low mid-stream with 3 entries buffered -> the next cycle has instr_valid=0, count=0, instr_out=0; the first post-reset fetch returns the correct data.
- FETCH_ALIGN_CHECK_EN: pc_in=0x6 -> no imem_req, output instr_fault=1, instr_out=0x00000013; with the macro undefined, imem_req=1 and instr_fault=0.
